uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 88 ++++++++
 tb/tb_uart_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter (MSB first, 16 s_tick per bit) with a one-entry holding register.
// Optional UART_TX_TWO_STOP_EN macro stretches the stop phase to two bit periods.
`timescale 1ns/1ps
module uart_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic [7:0] din,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_flag
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0] state;
  logic [3:0] tick;
  logic [2:0] nbit;
  logic [7:0] shreg, hold;
  logic       hold_full, adv, stop_last, frame_end, load;
`ifdef UART_TX_TWO_STOP_EN
  assign stop_last = nbit[0];
`else
  assign stop_last = 1'b1;
`endif
  assign tx_ready  = ~hold_full;
  assign tx_busy   = state != IDLE;
  assign adv       = s_tick && tick == 4'd15;
  assign frame_end = state == STOP && adv && stop_last;
  // A pending byte loads straight from IDLE or on the edge the stop bit ends, so frames abut.
  assign load      = hold_full && (state == IDLE || frame_end);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick         <= 4'd0;
      nbit         <= 3'd0;
      shreg        <= 8'd0;
      hold         <= 8'd0;
      hold_full    <= 1'b0;
      tx           <= 1'b1;
      tx_done_flag <= 1'b0;
    end else begin
      tx_done_flag <= frame_end;
      if (tx_start && tx_ready) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
      if (state != IDLE && s_tick) tick <= tick + 4'd1;
      if (load) begin
        shreg     <= hold;
        hold_full <= 1'b0;
        tick      <= 4'd0;
        nbit      <= 3'd0;
        state     <= START;
        tx        <= 1'b0;
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: if (adv) begin
            state <= DATA;
            nbit  <= 3'd0;
            tx    <= shreg[7];
            shreg <= {shreg[6:0], 1'b0};
          end
          DATA: if (adv) begin
            if (nbit == 3'd7) begin
              state <= STOP;
              nbit  <= 3'd0;
              tx    <= 1'b1;
            end else begin
              nbit  <= nbit + 3'd1;
              tx    <= shreg[7];
              shreg <= {shreg[6:0], 1'b0};
            end
          end
          STOP: if (adv) begin
            if (stop_last) state <= IDLE;
            else nbit <= nbit + 3'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a 16x-oversampling receiver model pops expected bytes.
`timescale 1ns/1ps
module tb_uart_tx;
  logic       clk = 1'b0, reset = 1'b0, s_tick = 1'b0, tx_start = 1'b0;
  logic [7:0] din = 8'd0;
  logic       tx_ready, tx, tx_busy, tx_done_flag;
  int         errors = 0, checks = 0, done_cnt = 0;
  logic [7:0] sb[$];
  logic       tick_en = 1'b1, prev_done = 1'b0;
  int         tcnt = 0, mstate = 0, mcnt = 0, nb = 0;
  logic [7:0] rx = 8'd0, exp_b;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .din(din), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done_flag(tx_done_flag)
  );

  // Receiver model counts the ticks the DUT saw on the preceding rising edge, then makes the next tick.
  always @(negedge clk) begin
    if (!reset) begin
      mstate = 0;
      prev_done = 1'b0;
    end else begin
      if (tx_done_flag) begin
        done_cnt++;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: tx_done_flag high for 2 clk, required 1");
        end
      end
      prev_done = tx_done_flag;
      case (mstate)
        0: if (tx == 1'b0) begin mstate = 1; mcnt = 0; end
        1: if (s_tick) begin
          mcnt++;
          if (mcnt == 8) begin
            checks++;
            if (tx !== 1'b0) begin errors++; $display("FAIL start_bit: tx=%b required 0", tx); end
            mstate = 2; mcnt = 0; nb = 0;
          end
        end
        2: if (s_tick) begin
          mcnt++;
          if (mcnt == 16) begin
            rx = {rx[6:0], tx};
            nb++;
            mcnt = 0;
            if (nb == 8) mstate = 3;
          end
        end
        3: if (s_tick) begin
          mcnt++;
          if (mcnt == 16) begin
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL stop_bit: tx=%b required 1", tx); end
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL rx_unexpected: got byte %h, required no frame", rx);
            end else begin
              exp_b = sb.pop_front();
              if (rx !== exp_b) begin errors++; $display("FAIL rx_byte: got %h required %h", rx, exp_b); end
            end
            mstate = 0;
          end
        end
        default: mstate = 0;
      endcase
    end
    if (tick_en) begin
      tcnt = (tcnt + 1) % 4;
      s_tick = (tcnt == 0);
    end else s_tick = 1'b0;
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      checks++; errors++;
      $display("FAIL send_wait: tx_ready=%b required 1", tx_ready);
    end
    din = b;
    tx_start = 1'b1;
    sb.push_back(b);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt < target) begin errors++; $display("FAIL done_timeout: done_cnt=%0d required %0d", done_cnt, target); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_ready, tx_done_flag} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_state: tx,busy,ready,done=%b required 1010", {tx, tx_busy, tx_ready, tx_done_flag});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] f;
    int d0;
    f = {1'b0, 8'hA5, 1'b1};
    d0 = done_cnt;
    send(8'hA5);
    checks++;
    if (tx_ready !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL capture: ready=%b tx=%b required 0 1", tx_ready, tx);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: tx=%b busy=%b required 0 1", tx, tx_busy);
    end
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 32 : 64) @(negedge clk);
      checks++;
      if (tx !== f[9-i]) begin errors++; $display("FAIL single_bit%0d: tx=%b required %b", i, tx, f[9-i]); end
    end
    wait_done(d0 + 1);
    repeat (80) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL single_done_count: %0d required %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_loopback();
    logic [7:0] bs[3] = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 3; i++) begin
      int d0 = done_cnt;
      send(bs[i]);
      wait_done(d0 + 1);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d0, n;
    d0 = done_cnt;
    send(8'h81);
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: ready=%b required 1", tx_ready); end
    repeat (200) @(negedge clk);
    send(8'h7E);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: ready=%b required 0", tx_ready); end
    din = 8'h99;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ignored: ready=%b required 0", tx_ready); end
    n = 0;
    while (!tx_done_flag && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if ({tx_done_flag, tx, tx_ready, tx_busy} !== 4'b1011) begin
      errors++;
      $display("FAIL b2b_no_gap: done,tx,ready,busy=%b required 1011", {tx_done_flag, tx, tx_ready, tx_busy});
    end
    wait_done(d0 + 2);
    repeat (100) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: busy=%b tx=%b pending=%0d required 0 1 0", tx_busy, tx, sb.size());
    end
  endtask

  task automatic test_tick_gating();
    int d0, changes;
    logic t0;
    d0 = done_cnt;
    send(8'hC3);
    @(negedge clk);
    repeat (32 + 128) @(negedge clk);
    t0 = tx;
    changes = 0;
    tick_en = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== t0 || tx_busy !== 1'b1) changes++;
    end
    tick_en = 1'b1;
    checks++;
    if (changes != 0) begin errors++; $display("FAIL tick_gating: %0d changed cycles, required 0", changes); end
    wait_done(d0 + 1);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_stop_length();
    int n, lo, hi;
`ifdef UART_TX_TWO_STOP_EN
    lo = 701; hi = 704;
`else
    lo = 637; hi = 640;
`endif
    send(8'h0F);
    @(negedge clk);
    n = 0;
    while (!tx_done_flag && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n < lo || n > hi) begin errors++; $display("FAIL stop_length: frame %0d clk, required %0d..%0d", n, lo, hi); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int d0;
    send(8'h55);
    @(negedge clk);
    send(8'h33);
    repeat (32 + 64 * 5 - 1) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_reset_pre: tx=%b required 0", tx); end
    d0 = done_cnt;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tx, tx_busy, tx_ready, tx_done_flag} !== 4'b1010) begin
      errors++;
      $display("FAIL mid_reset_now: tx,busy,ready,done=%b required 1010", {tx, tx_busy, tx_ready, tx_done_flag});
    end
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (800) @(negedge clk);
    checks++;
    if (done_cnt != d0 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: dones=%0d busy=%b tx=%b required 0 0 1", done_cnt - d0, tx_busy, tx);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_back_to_back();
    test_tick_gating();
    test_stop_length();
    test_mid_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: %0d pending, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
